// File: rtl/idu1_scoreboard_if.sv
// Bus bundle between decode, the IDU1 scoreboard issue stage and the EXU.
// The slave modport is the scoreboard's view; master is the surrounding pipeline.
interface idu1_scoreboard_if #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NUM_WB = 2,
   parameter int AW     = $clog2(NREGS)
);
   logic                     in_valid;
   logic                     in_ready;
   logic                     in_rs1_en;
   logic                     in_rs2_en;
   logic [AW-1:0]            in_rs1_addr;
   logic [AW-1:0]            in_rs2_addr;
   logic [XLEN-1:0]          in_rs1_data;
   logic [XLEN-1:0]          in_rs2_data;
   logic                     in_rd_en;
   logic [AW-1:0]            in_rd_addr;
   logic [1:0]               in_unit;
   logic [63:0]              in_payload;
   logic                     out_valid;
   logic                     out_ready;
   logic [XLEN-1:0]          out_rs1_data;
   logic [XLEN-1:0]          out_rs2_data;
   logic                     out_rd_en;
   logic [AW-1:0]            out_rd_addr;
   logic [1:0]               out_unit;
   logic [63:0]              out_payload;
   logic [NUM_WB-1:0]        wb_valid;
   logic [NUM_WB*AW-1:0]     wb_rd_addr;
   logic [NUM_WB*XLEN-1:0]   wb_data;
   logic                     div_busy;
   logic                     flush;
   logic [NREGS-1:0]         pending;

   modport slave (
      input  in_valid, in_rs1_en, in_rs2_en, in_rs1_addr, in_rs2_addr,
             in_rs1_data, in_rs2_data, in_rd_en, in_rd_addr, in_unit, in_payload,
             out_ready, wb_valid, wb_rd_addr, wb_data, div_busy, flush,
      output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd_en,
             out_rd_addr, out_unit, out_payload, pending
   );

   modport master (
      output in_valid, in_rs1_en, in_rs2_en, in_rs1_addr, in_rs2_addr,
             in_rs1_data, in_rs2_data, in_rd_en, in_rd_addr, in_unit, in_payload,
             out_ready, wb_valid, wb_rd_addr, wb_data, div_busy, flush,
      input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd_en,
             out_rd_addr, out_unit, out_payload, pending
   );
endinterface

// File: rtl/idu1_scoreboard.sv
// IDU1 issue stage with a per-register pending-write scoreboard.
// Stalls only on true RAW/WAW hazards or a busy divider; write-back results
// are forwarded into source operands in the same cycle they retire.
module idu1_scoreboard #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NUM_WB = 2,
   parameter int AW     = $clog2(NREGS)
) (
   input logic                clk,
   input logic                rst,
   idu1_scoreboard_if.slave   bus
);
   localparam logic [1:0] UNIT_DIV = 2'd2;

   // True when any write-back port retires register r this cycle (x0 never hits).
   function automatic logic wb_hit(input logic [AW-1:0] r,
                                   input logic [NUM_WB-1:0] v,
                                   input logic [NUM_WB*AW-1:0] a);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_WB; i++) begin
         if (v[i] && (a[i*AW +: AW] == r) && (r != {AW{1'b0}})) begin
            hit = 1'b1;
         end else begin
            hit = hit;
         end
      end
      return hit;
   endfunction

   // Operand value: highest-index hitting port wins, x0 reads as zero.
   function automatic logic [XLEN-1:0] wb_fwd(input logic [AW-1:0] r,
                                              input logic [XLEN-1:0] rf_data,
                                              input logic [NUM_WB-1:0] v,
                                              input logic [NUM_WB*AW-1:0] a,
                                              input logic [NUM_WB*XLEN-1:0] d);
      logic [XLEN-1:0] val;
      val = rf_data;
      for (int i = 0; i < NUM_WB; i++) begin
         if (v[i] && (a[i*AW +: AW] == r)) begin
            val = d[i*XLEN +: XLEN];
         end else begin
            val = val;
         end
      end
      if (r == {AW{1'b0}}) begin
         val = {XLEN{1'b0}};
      end else begin
         val = val;
      end
      return val;
   endfunction

   logic [NREGS-1:0] pending_q, pending_d;
   logic [NREGS-1:0] wb_clr_s, rd_set_s;
   logic             rs1_hit_s, rs2_hit_s, rd_hit_s;
   logic [XLEN-1:0]  rs1_fwd_s, rs2_fwd_s;
   logic             rs1_ok_s, rs2_ok_s, waw_ok_s, struct_ok_s, slot_free_s;
   logic             in_ready_s, issue_s;

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
   logic             out_rd_en_q, out_rd_en_d;
   logic [AW-1:0]    out_rd_addr_q, out_rd_addr_d;
   logic [1:0]       out_unit_q, out_unit_d;
   logic [63:0]      out_payload_q, out_payload_d;

   // Forwarding lookups for both sources and the destination.
   always_comb begin
      rs1_hit_s = wb_hit(bus.in_rs1_addr, bus.wb_valid, bus.wb_rd_addr);
      rs2_hit_s = wb_hit(bus.in_rs2_addr, bus.wb_valid, bus.wb_rd_addr);
      rd_hit_s  = wb_hit(bus.in_rd_addr,  bus.wb_valid, bus.wb_rd_addr);
      rs1_fwd_s = wb_fwd(bus.in_rs1_addr, bus.in_rs1_data, bus.wb_valid, bus.wb_rd_addr, bus.wb_data);
      rs2_fwd_s = wb_fwd(bus.in_rs2_addr, bus.in_rs2_data, bus.wb_valid, bus.wb_rd_addr, bus.wb_data);
   end

   assign rs1_ok_s    = ~bus.in_rs1_en | (bus.in_rs1_addr == {AW{1'b0}}) |
                        ~pending_q[bus.in_rs1_addr] | rs1_hit_s;
   assign rs2_ok_s    = ~bus.in_rs2_en | (bus.in_rs2_addr == {AW{1'b0}}) |
                        ~pending_q[bus.in_rs2_addr] | rs2_hit_s;
   assign waw_ok_s    = ~bus.in_rd_en | (bus.in_rd_addr == {AW{1'b0}}) |
                        ~pending_q[bus.in_rd_addr] | rd_hit_s;
   assign struct_ok_s = ~((bus.in_unit == UNIT_DIV) & bus.div_busy);
   assign slot_free_s = ~out_valid_q | bus.out_ready;
   assign in_ready_s  = slot_free_s & rs1_ok_s & rs2_ok_s & waw_ok_s & struct_ok_s & ~bus.flush;
   assign issue_s     = bus.in_valid & in_ready_s;

   // Scoreboard next state: clear on write-back, then set on issue (set wins).
   always_comb begin
      wb_clr_s = {NREGS{1'b0}};
      rd_set_s = {NREGS{1'b0}};
      for (int i = 0; i < NUM_WB; i++) begin
         if (bus.wb_valid[i]) begin
            wb_clr_s[bus.wb_rd_addr[i*AW +: AW]] = 1'b1;
         end else begin
            wb_clr_s = wb_clr_s;
         end
      end
      if (issue_s && bus.in_rd_en) begin
         rd_set_s[bus.in_rd_addr] = 1'b1;
      end else begin
         rd_set_s = rd_set_s;
      end
      if (bus.flush) begin
         pending_d = {NREGS{1'b0}};
      end else begin
         pending_d = ((pending_q & ~wb_clr_s) | rd_set_s) & {{(NREGS-1){1'b1}}, 1'b0};
      end
   end

   // Issue register next state: kill on flush, load on issue, drain on accept.
   always_comb begin
      out_valid_d   = out_valid_q;
      out_rs1_d     = out_rs1_q;
      out_rs2_d     = out_rs2_q;
      out_rd_en_d   = out_rd_en_q;
      out_rd_addr_d = out_rd_addr_q;
      out_unit_d    = out_unit_q;
      out_payload_d = out_payload_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (issue_s) begin
         out_valid_d   = 1'b1;
         out_rs1_d     = rs1_fwd_s;
         out_rs2_d     = rs2_fwd_s;
         out_rd_en_d   = bus.in_rd_en;
         out_rd_addr_d = bus.in_rd_addr;
         out_unit_d    = bus.in_unit;
         out_payload_d = bus.in_payload;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q     <= {NREGS{1'b0}};
         out_valid_q   <= 1'b0;
         out_rs1_q     <= {XLEN{1'b0}};
         out_rs2_q     <= {XLEN{1'b0}};
         out_rd_en_q   <= 1'b0;
         out_rd_addr_q <= {AW{1'b0}};
         out_unit_q    <= 2'd0;
         out_payload_q <= 64'd0;
      end else begin
         pending_q     <= pending_d;
         out_valid_q   <= out_valid_d;
         out_rs1_q     <= out_rs1_d;
         out_rs2_q     <= out_rs2_d;
         out_rd_en_q   <= out_rd_en_d;
         out_rd_addr_q <= out_rd_addr_d;
         out_unit_q    <= out_unit_d;
         out_payload_q <= out_payload_d;
      end
   end

   assign bus.in_ready     = in_ready_s;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_rs1_data = out_rs1_q;
   assign bus.out_rs2_data = out_rs2_q;
   assign bus.out_rd_en    = out_rd_en_q;
   assign bus.out_rd_addr  = out_rd_addr_q;
   assign bus.out_unit     = out_unit_q;
   assign bus.out_payload  = out_payload_q;
   assign bus.pending      = pending_q;
endmodule

// File: tb/tb_idu1_scoreboard.sv
// Directed testbench for idu1_scoreboard. Issued instructions push their
// hand-computed expected output into a queue; a monitor pops and compares
// whenever the EXU side takes an output.
module tb_idu1_scoreboard;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   idu1_scoreboard_if bif ();
   idu1_scoreboard dut (.clk(clk), .rst(rst), .bus(bif));

   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [7:0]  ctl;
      logic [63:0] pl;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t drop_e;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
   endtask

   // Monitor: compare every accepted output against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bif.out_valid && bif.out_ready) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_out: got payload 0x%0h expected no output", bif.out_payload);
         end else begin
            mon_e = exp_q.pop_front();
            check("mon_rs1", bif.out_rs1_data, mon_e.rs1);
            check("mon_rs2", bif.out_rs2_data, mon_e.rs2);
            check("mon_ctl", {bif.out_rd_en, bif.out_rd_addr, bif.out_unit}, mon_e.ctl);
            check("mon_payload", bif.out_payload, mon_e.pl);
         end
      end
   end

   task automatic instr(input logic v, input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic [1:0] unit, input logic [63:0] pl);
      bif.in_valid = v;    bif.in_rs1_en = 1'b1; bif.in_rs2_en = 1'b1;
      bif.in_rs1_addr = r1; bif.in_rs1_data = d1;
      bif.in_rs2_addr = r2; bif.in_rs2_data = d2;
      bif.in_rd_en = 1'b1; bif.in_rd_addr = rd;
      bif.in_unit = unit;  bif.in_payload = pl;
   endtask

   task automatic wb(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1);
      bif.wb_valid = v; bif.wb_rd_addr = {a1, a0}; bif.wb_data = {d1, d0};
   endtask

   // One cycle: check in_ready, queue the expected output if the bench expects
   // an issue, cross the clock edge, then return inputs to idle.
   task automatic cyc(input string nm, input logic exp_rdy, input logic [31:0] e1, input logic [31:0] e2);
      exp_t e;
      #2;
      check({nm, "_in_ready"}, bif.in_ready, exp_rdy);
      if (exp_rdy && bif.in_valid) begin
         e.rs1 = e1; e.rs2 = e2;
         e.ctl = {bif.in_rd_en, bif.in_rd_addr, bif.in_unit};
         e.pl  = bif.in_payload;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      bif.in_valid = 1'b0; bif.in_rs1_en = 1'b0; bif.in_rs2_en = 1'b0; bif.in_rd_en = 1'b0;
      bif.flush = 1'b0;
      wb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
   endtask

   task automatic pend(input string nm, input logic [31:0] want);
      check(nm, bif.pending, want);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      instr(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 2'd0, 64'd0);
      bif.in_rs1_en = 1'b0; bif.in_rs2_en = 1'b0; bif.in_rd_en = 1'b0;
      wb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      bif.out_ready = 1'b1; bif.div_busy = 1'b0; bif.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bif.out_valid, 1'b0);
      pend("rst_pending", 32'h0);
      check("rst_out_rs1", bif.out_rs1_data, 32'h0);
      check("rst_out_payload", bif.out_payload, 64'h0);
      rst = 1'b0;

      // 1: independent stream
      instr(1'b1, 5'd10, 32'h10, 5'd11, 32'h11, 5'd1, 2'd0, 64'd1);
      cyc("t1_a", 1'b1, 32'h10, 32'h11);   pend("t1_p1", 32'h2);
      check("t1_ov1", bif.out_valid, 1'b1);
      instr(1'b1, 5'd12, 32'h12, 5'd13, 32'h13, 5'd2, 2'd0, 64'd2);
      wb(2'b01, 5'd1, 32'h99, 5'd0, 32'd0);
      cyc("t1_b", 1'b1, 32'h12, 32'h13);   pend("t1_p2", 32'h4);
      check("t1_ov2", bif.out_valid, 1'b1);
      wb(2'b01, 5'd2, 32'h98, 5'd0, 32'd0);
      cyc("t1_c", 1'b1, 32'h0, 32'h0);     pend("t1_p3", 32'h0);
      check("t1_ov3", bif.out_valid, 1'b0);

      // 2: RAW stall on MUL result, then same-cycle forward from port 1
      instr(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd5, 2'd1, 64'd3);
      cyc("t2_mul", 1'b1, 32'h1, 32'h2);   pend("t2_p0", 32'h20);
      for (int k = 0; k < 3; k++) begin
         instr(1'b1, 5'd5, 32'hDEAD, 5'd0, 32'h55, 5'd6, 2'd0, 64'd4);
         cyc("t2_stall", 1'b0, 32'h0, 32'h0); pend("t2_pstall", 32'h20);
      end
      instr(1'b1, 5'd5, 32'hDEAD, 5'd0, 32'h55, 5'd6, 2'd0, 64'd4);
      wb(2'b10, 5'd0, 32'd0, 5'd5, 32'h1234);
      cyc("t2_fwd", 1'b1, 32'h1234, 32'h0); pend("t2_p1", 32'h40);
      wb(2'b01, 5'd6, 32'h1, 5'd0, 32'd0);
      cyc("t2_clr", 1'b1, 32'h0, 32'h0);   pend("t2_p2", 32'h0);

      // 3: WAW stall behind DIV, issue in WB cycle keeps pending (set wins)
      instr(1'b1, 5'd1, 32'h7, 5'd2, 32'h8, 5'd7, 2'd2, 64'd5);
      cyc("t3_div", 1'b1, 32'h7, 32'h8);   pend("t3_p0", 32'h80);
      for (int k = 0; k < 2; k++) begin
         instr(1'b1, 5'd3, 32'h3, 5'd4, 32'h4, 5'd7, 2'd0, 64'd6);
         cyc("t3_waw", 1'b0, 32'h0, 32'h0); pend("t3_pstall", 32'h80);
      end
      instr(1'b1, 5'd3, 32'h3, 5'd4, 32'h4, 5'd7, 2'd0, 64'd6);
      wb(2'b01, 5'd7, 32'h77, 5'd0, 32'd0);
      cyc("t3_set", 1'b1, 32'h3, 32'h4);   pend("t3_p1", 32'h80);
      wb(2'b01, 5'd7, 32'h78, 5'd0, 32'd0);
      cyc("t3_clr", 1'b1, 32'h0, 32'h0);   pend("t3_p2", 32'h0);

      // 4: structural hazard on busy divider
      bif.div_busy = 1'b1;
      instr(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd8, 2'd2, 64'd7);
      cyc("t4_div", 1'b0, 32'h0, 32'h0);   pend("t4_p0", 32'h0);
      instr(1'b1, 5'd1, 32'h21, 5'd2, 32'h22, 5'd9, 2'd0, 64'd8);
      cyc("t4_alu", 1'b1, 32'h21, 32'h22); pend("t4_p1", 32'h200);
      bif.div_busy = 1'b0;
      wb(2'b01, 5'd9, 32'h5, 5'd0, 32'd0);
      cyc("t4_clr", 1'b1, 32'h0, 32'h0);   pend("t4_p2", 32'h0);

      // 5: backpressure holds the issue register
      instr(1'b1, 5'd1, 32'h31, 5'd2, 32'h32, 5'd10, 2'd0, 64'd9);
      cyc("t5_i", 1'b1, 32'h31, 32'h32);   pend("t5_p0", 32'h400);
      bif.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         instr(1'b1, 5'd3, 32'h41, 5'd4, 32'h42, 5'd11, 2'd0, 64'd10);
         cyc("t5_bp", 1'b0, 32'h0, 32'h0);
         check("t5_hold_valid", bif.out_valid, 1'b1);
         check("t5_hold_payload", bif.out_payload, 64'd9);
         check("t5_hold_rs1", bif.out_rs1_data, 32'h31);
      end
      bif.out_ready = 1'b1;
      instr(1'b1, 5'd3, 32'h41, 5'd4, 32'h42, 5'd11, 2'd0, 64'd10);
      cyc("t5_go", 1'b1, 32'h41, 32'h42);  pend("t5_p1", 32'hC00);
      wb(2'b11, 5'd10, 32'h1, 5'd11, 32'h2);
      cyc("t5_clr", 1'b1, 32'h0, 32'h0);   pend("t5_p2", 32'h0);

      // 6: dual write-back to x3 (port 1 wins), flush, x0 source
      instr(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 2'd0, 64'd11);
      cyc("t6_x3", 1'b1, 32'h1, 32'h2);    pend("t6_p0", 32'h8);
      instr(1'b1, 5'd3, 32'hFFFF, 5'd3, 32'hFFFF, 5'd12, 2'd0, 64'd12);
      wb(2'b11, 5'd3, 32'hA, 5'd3, 32'hB);
      cyc("t6_dual", 1'b1, 32'hB, 32'hB);  pend("t6_p1", 32'h1000);
      bif.out_ready = 1'b0; bif.flush = 1'b1;
      instr(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd13, 2'd0, 64'd13);
      cyc("t6_flush", 1'b0, 32'h0, 32'h0); pend("t6_p2", 32'h0);
      check("t6_flush_valid", bif.out_valid, 1'b0);
      if (exp_q.size() > 0) drop_e = exp_q.pop_back();
      bif.out_ready = 1'b1;
      instr(1'b1, 5'd0, 32'hBAD, 5'd5, 32'h5, 5'd14, 2'd0, 64'd14);
      cyc("t6_x0", 1'b1, 32'h0, 32'h5);    pend("t6_p3", 32'h4000);
      wb(2'b01, 5'd14, 32'h1, 5'd0, 32'd0);
      cyc("t6_clr", 1'b1, 32'h0, 32'h0);   pend("t6_p4", 32'h0);

      // 7: reset while stalled drops the held instruction
      instr(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd15, 2'd0, 64'd15);
      cyc("t7_i", 1'b1, 32'h1, 32'h2);     pend("t7_p0", 32'h8000);
      bif.out_ready = 1'b0;
      cyc("t7_hold", 1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t7_rst_valid", bif.out_valid, 1'b0);
      pend("t7_rst_pending", 32'h0);
      check("t7_rst_payload", bif.out_payload, 64'h0);
      if (exp_q.size() > 0) drop_e = exp_q.pop_back();
      bif.out_ready = 1'b1;

      repeat (3) cyc("idle", 1'b1, 32'h0, 32'h0);
      check("queue_empty", exp_q.size(), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/idu1_scoreboard.md
Name: idu1_scoreboard

Overview:
- Parametrised successor to the IDU1 issue stage. Replaces coarse busy-based stalling with a per-register pending-write scoreboard.
- Sits between decode (IDU0 + register-file read) and EXU. Holds one instruction in a valid/ready output register.
- Forwards from NUM_WB write-back ports into source operands. Stalls only on true RAW/WAW hazards or a blocking divider.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural registers (x0 hard-wired zero)
NUM_WB, 2, independent write-back ports (e.g. ALU/LSU, MUL/DIV)
AW, $clog2(NREGS), register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle
in_rs1_en, in_rs2_en  in  1  source operand used
in_rs1_addr, in_rs2_addr  in  AW  source addresses
in_rs1_data, in_rs2_data  in  XLEN  register-file read data
in_rd_en  in  1  writes a destination
in_rd_addr  in  AW  destination
in_unit  in  2  0=ALU 1=MUL 2=DIV 3=LSU
in_payload  in  64  opaque decode bits (imm, ops, tag), passed through
out_valid  out  1  issue register valid
out_ready  in  1  EXU accepts
out_rs1_data, out_rs2_data  out  XLEN  resolved operands
out_rd_en, out_rd_addr, out_unit, out_payload  out  -  registered copies
wb_valid  in  NUM_WB  write-back strobes
wb_rd_addr  in  NUM_WB*AW  write-back addresses, port i at [i*AW +: AW]
wb_data  in  NUM_WB*XLEN  write-back data
div_busy  in  1  divider occupied
flush  in  1  kill issue register and scoreboard
pending  out  NREGS  scoreboard state (debug/verification)

Behaviour:
- Reset: pending=0, out_valid=0, all out_* data=0.
- wb_hit(r): some port i has wb_valid[i] & wb_rd_addr_i==r & r!=0. If several ports hit the same r, the highest index supplies data.
- src_ok(s): ~en_s | addr_s==0 | ~pending[addr_s] | wb_hit(addr_s).
- waw_ok: ~in_rd_en | in_rd_addr==0 | ~pending[in_rd_addr] | wb_hit(in_rd_addr).
- struct_ok: ~(in_unit==DIV & div_busy).
- slot_free: ~out_valid | out_ready.
- in_ready = slot_free & src_ok(rs1) & src_ok(rs2) & waw_ok & struct_ok & ~flush. Combinational, independent of in_valid.
- Issue (in_valid & in_ready):
  - The output register loads next cycle with all fields.
  - Each operand takes wb_data when wb_hit on its address, else in_*_data. Address 0 forces data 0.
- Output register holds unchanged while out_valid & ~out_ready. out_valid clears when out_ready and there is no issue.
- Scoreboard, per cycle:
  - Clear pending[r] for every wb_hit(r).
  - Then set pending[in_rd_addr] on issue with in_rd_en & rd!=0.
  - Set wins over clear on the same register in the same cycle.
  - pending[0] is always 0.
- Latency: issue to out_valid is 1 cycle. WB-to-dependent issue is 0 cycles (same-cycle forward).
- flush:
  - Next cycle out_valid=0 and pending=0.
  - Same-cycle issue is blocked (in_ready=0).
  - The EXU guarantees no WB for flushed instructions after flush.
  - flush with rst: rst dominates.
- WB to a non-pending register is legal: it is forwarded only and pending is unchanged.
- Reset mid-stall drops the held instruction; no partial state survives.

Test Plan:
1. Independent stream: ADD x1, then ADD x2 with out_ready=1 -> in_ready=1 every cycle; out_valid pulses each cycle; pending[1], then pending[2], set and cleared by WB.
2. MUL x5 issued; next instr reads x5; no WB for 3 cycles -> in_ready=0 for 3 cycles. On cycle 4 wb_valid[1]=1, addr 5, data 0x1234 -> same-cycle issue; out_rs1_data=0x1234; pending[5]=0.
3. WAW: DIV x7 pending; ADD x7 presented -> stalls until WB x7. Issue in the WB cycle -> pending[7] stays 1 (set wins).
4. div_busy=1 with a DIV presented -> in_ready=0. Non-DIV independent op presented instead -> issues.
5. Backpressure: out_ready=0 for 4 cycles -> outputs stable, in_ready=0. Then out_ready=1 -> next instr issues the same cycle.
6. Both WB ports write x3 (0xA, 0xB) while x3 is consumed -> operand=0xB. flush asserted -> out_valid=0 and pending=0 next cycle. Register x0 source -> operand 0.
